// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game-state controller: debounces the six push buttons, moves the
// cursor, places alternating marks and detects win or draw for the VGA stage.
module ttt_board_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_new,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [3:0] cursor,
  output logic       turn,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam int NB      = 6;
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_SEL   = 4;
  localparam int B_NEW   = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_NEW,
    ACT_SEL,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } act_t;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    WIN,
    DRAW
  } state_t;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    db_level;
  logic [NB-1:0]    armed;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] db_cnt [NB];

  act_t       act;
  state_t     state;
  logic [1:0] board [9];
  logic [3:0] move_cnt;
  logic [1:0] mover;
  logic       mover_wins;
  logic [3:0] cursor_moved;

  assign btn_raw = {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Until a button has been seen stably released after reset, the counter
  // times the released level instead, so a button held through reset never fires.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      db_level <= '0;
      armed    <= '0;
      press    <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < NB; i++) begin
        if (!armed[i]) begin
          if (sync2[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == CNT_LAST) begin
            armed[i]  <= 1'b1;
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_level[i] <= sync2[i];
          press[i]    <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    act = ACT_NONE;
    if      (press[B_NEW])   act = ACT_NEW;
    else if (press[B_SEL])   act = ACT_SEL;
    else if (press[B_UP])    act = ACT_UP;
    else if (press[B_DOWN])  act = ACT_DOWN;
    else if (press[B_LEFT])  act = ACT_LEFT;
    else if (press[B_RIGHT]) act = ACT_RIGHT;
  end

  function automatic logic [3:0] step_cursor(input logic [3:0] cur, input act_t a);
    logic [3:0] idx;
    logic [3:0] row;
    logic [3:0] col;
    idx = cur - 4'd1;
    row = (idx >= 4'd6) ? 4'd2 : ((idx >= 4'd3) ? 4'd1 : 4'd0);
    col = idx - 4'd3 * row;
    case (a)
      ACT_UP:    row = (row == 4'd0) ? 4'd2 : row - 4'd1;
      ACT_DOWN:  row = (row == 4'd2) ? 4'd0 : row + 4'd1;
      ACT_LEFT:  col = (col == 4'd0) ? 4'd2 : col - 4'd1;
      ACT_RIGHT: col = (col == 4'd2) ? 4'd0 : col + 4'd1;
      default:   ;
    endcase
    return 4'd3 * row + col + 4'd1;
  endfunction

  function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] code);
    return (a == code) && (b == code) && (c == code);
  endfunction

  assign mover        = turn ? 2'b10 : 2'b01;
  assign cursor_moved = step_cursor(cursor, act);

  always_comb begin
    mover_wins = line3(board[0], board[1], board[2], mover) |
                 line3(board[3], board[4], board[5], mover) |
                 line3(board[6], board[7], board[8], mover) |
                 line3(board[0], board[3], board[6], mover) |
                 line3(board[1], board[4], board[7], mover) |
                 line3(board[2], board[5], board[8], mover) |
                 line3(board[0], board[4], board[8], mover) |
                 line3(board[2], board[4], board[6], mover);
  end

  // A new-game pulse overrides every state, including the one-cycle CHECK.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state     <= PLAY;
      for (int k = 0; k < 9; k++) board[k] <= 2'b00;
      cursor    <= 4'd5;
      turn      <= 1'b0;
      winner    <= 2'b00;
      game_over <= 1'b0;
      move_cnt  <= 4'd0;
    end else if (act == ACT_NEW) begin
      state     <= PLAY;
      for (int k = 0; k < 9; k++) board[k] <= 2'b00;
      cursor    <= 4'd5;
      turn      <= 1'b0;
      winner    <= 2'b00;
      game_over <= 1'b0;
      move_cnt  <= 4'd0;
    end else begin
      case (state)
        PLAY: begin
          if (act == ACT_SEL) begin
            if (board[cursor - 4'd1] == 2'b00) begin
              board[cursor - 4'd1] <= mover;
              move_cnt             <= move_cnt + 4'd1;
              state                <= CHECK;
            end
          end else if (act != ACT_NONE) begin
            cursor <= cursor_moved;
          end
        end
        CHECK: begin
          if (mover_wins) begin
            state     <= WIN;
            winner    <= mover;
            game_over <= 1'b1;
          end else if (move_cnt == 4'd9) begin
            state     <= DRAW;
            winner    <= 2'b11;
            game_over <= 1'b1;
          end else begin
            turn  <= ~turn;
            state <= PLAY;
          end
        end
        WIN, DRAW: ;
        default: state <= PLAY;
      endcase
    end
  end

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Bench for ttt_board_ctrl: hand-derived vector table, multi-cycle debounce and
// reset sequences, then random button presses against a game-level model.
module tb_ttt_board_ctrl;

  localparam int D      = 4;
  localparam int HOLD   = D + 4;
  localparam int SETTLE = D + 8;

  localparam int A_NONE  = 0;
  localparam int A_UP    = 1;
  localparam int A_DOWN  = 2;
  localparam int A_LEFT  = 3;
  localparam int A_RIGHT = 4;
  localparam int A_SEL   = 5;
  localparam int A_NEW   = 6;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic btn_sel = 1'b0, btn_new = 1'b0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [3:0] cursor;
  logic       turn;
  logic [1:0] winner;
  logic       game_over;
  logic [17:0] board_now;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int act;
    int cur;
    int board;
    int turn;
    int win;
    int over;
  } vec_t;

  vec_t tbl[$];

  int m_board [9];
  int m_cur, m_turn, m_win, m_over, m_moves;
  int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                       '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  always #20 clk_25 = ~clk_25;

  assign board_now = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  ttt_board_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk_25(clk_25), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .btn_new(btn_new),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .cursor(cursor), .turn(turn), .winner(winner), .game_over(game_over)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic drive_button(input int act, input logic level);
    case (act)
      A_UP:    btn_up    = level;
      A_DOWN:  btn_down  = level;
      A_LEFT:  btn_left  = level;
      A_RIGHT: btn_right = level;
      A_SEL:   btn_sel   = level;
      A_NEW:   btn_new   = level;
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input int act, input int hold);
    drive_button(act, 1'b1);
    wait_cycles(hold);
    drive_button(act, 1'b0);
    wait_cycles(SETTLE);
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int eb, input int ec,
                             input int et, input int ew, input int eo);
    check_val({name, ".board"},  int'(board_now), eb);
    check_val({name, ".cursor"}, int'(cursor),    ec);
    check_val({name, ".turn"},   int'(turn),      et);
    check_val({name, ".winner"}, int'(winner),    ew);
    check_val({name, ".over"},   int'(game_over), eo);
  endtask

  // Board literal: nine characters for cells 1..9, '.' empty, '1'/'2' players.
  function automatic int bstr(input string s);
    int  b;
    byte ch;
    b = 0;
    for (int k = 0; k < 9; k++) begin
      ch = s[k];
      if (ch == "1") b = b | (1 << (2 * k));
      else if (ch == "2") b = b | (2 << (2 * k));
    end
    return b;
  endfunction

  task automatic add_vec(input int act, input int cur, input string b,
                         input int t, input int w, input int o);
    vec_t v;
    v.act = act; v.cur = cur; v.board = bstr(b);
    v.turn = t; v.win = w; v.over = o;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) m_board[k] = 0;
    m_cur = 5; m_turn = 0; m_win = 0; m_over = 0; m_moves = 0;
  endtask

  task automatic model_apply(input int act);
    int r, c, code;
    bit won;
    if (act == A_NEW) begin
      model_reset();
      return;
    end
    if (m_over != 0) return;
    r = (m_cur - 1) / 3;
    c = (m_cur - 1) % 3;
    case (act)
      A_UP:    r = (r + 2) % 3;
      A_DOWN:  r = (r + 1) % 3;
      A_LEFT:  c = (c + 2) % 3;
      A_RIGHT: c = (c + 1) % 3;
      A_SEL: begin
        if (m_board[m_cur-1] == 0) begin
          code = m_turn + 1;
          m_board[m_cur-1] = code;
          m_moves++;
          won = 0;
          for (int l = 0; l < 8; l++)
            if (m_board[lines[l][0]] == code && m_board[lines[l][1]] == code &&
                m_board[lines[l][2]] == code) won = 1;
          if (won) begin
            m_win = code; m_over = 1;
          end else if (m_moves == 9) begin
            m_win = 3; m_over = 1;
          end else begin
            m_turn = 1 - m_turn;
          end
        end
      end
      default: ;
    endcase
    m_cur = r * 3 + c + 1;
  endtask

  function automatic int model_board();
    int b;
    b = 0;
    for (int k = 0; k < 9; k++) b = b | (m_board[k] << (2 * k));
    return b;
  endfunction

  initial begin
    int k;
    int act;
    int r;

    // Second move at 5 is rejected, then cursor wraps, a P1 win, a draw.
    add_vec(A_SEL,   5, "....1....", 1, 0, 0);
    add_vec(A_RIGHT, 6, "....1....", 1, 0, 0);
    add_vec(A_RIGHT, 4, "....1....", 1, 0, 0);
    add_vec(A_UP,    1, "....1....", 1, 0, 0);
    add_vec(A_RIGHT, 2, "....1....", 1, 0, 0);
    add_vec(A_UP,    8, "....1....", 1, 0, 0);
    add_vec(A_DOWN,  2, "....1....", 1, 0, 0);
    add_vec(A_RIGHT, 3, "....1....", 1, 0, 0);
    add_vec(A_RIGHT, 1, "....1....", 1, 0, 0);
    add_vec(A_NEW,   5, ".........", 0, 0, 0);
    add_vec(A_UP,    2, ".........", 0, 0, 0);
    add_vec(A_LEFT,  1, ".........", 0, 0, 0);
    add_vec(A_SEL,   1, "1........", 1, 0, 0);
    add_vec(A_DOWN,  4, "1........", 1, 0, 0);
    add_vec(A_SEL,   4, "1..2.....", 0, 0, 0);
    add_vec(A_UP,    1, "1..2.....", 0, 0, 0);
    add_vec(A_RIGHT, 2, "1..2.....", 0, 0, 0);
    add_vec(A_SEL,   2, "11.2.....", 1, 0, 0);
    add_vec(A_DOWN,  5, "11.2.....", 1, 0, 0);
    add_vec(A_SEL,   5, "11.22....", 0, 0, 0);
    add_vec(A_UP,    2, "11.22....", 0, 0, 0);
    add_vec(A_RIGHT, 3, "11.22....", 0, 0, 0);
    add_vec(A_SEL,   3, "11122....", 0, 1, 1);
    add_vec(A_SEL,   3, "11122....", 0, 1, 1);
    add_vec(A_LEFT,  3, "11122....", 0, 1, 1);
    add_vec(A_NEW,   5, ".........", 0, 0, 0);
    add_vec(A_UP,    2, ".........", 0, 0, 0);
    add_vec(A_LEFT,  1, ".........", 0, 0, 0);
    add_vec(A_SEL,   1, "1........", 1, 0, 0);
    add_vec(A_RIGHT, 2, "1........", 1, 0, 0);
    add_vec(A_SEL,   2, "12.......", 0, 0, 0);
    add_vec(A_RIGHT, 3, "12.......", 0, 0, 0);
    add_vec(A_SEL,   3, "121......", 1, 0, 0);
    add_vec(A_DOWN,  6, "121......", 1, 0, 0);
    add_vec(A_LEFT,  5, "121......", 1, 0, 0);
    add_vec(A_SEL,   5, "121.2....", 0, 0, 0);
    add_vec(A_LEFT,  4, "121.2....", 0, 0, 0);
    add_vec(A_SEL,   4, "12112....", 1, 0, 0);
    add_vec(A_RIGHT, 5, "12112....", 1, 0, 0);
    add_vec(A_RIGHT, 6, "12112....", 1, 0, 0);
    add_vec(A_SEL,   6, "121122...", 0, 0, 0);
    add_vec(A_DOWN,  9, "121122...", 0, 0, 0);
    add_vec(A_LEFT,  8, "121122...", 0, 0, 0);
    add_vec(A_SEL,   8, "121122.1.", 1, 0, 0);
    add_vec(A_LEFT,  7, "121122.1.", 1, 0, 0);
    add_vec(A_SEL,   7, "12112221.", 0, 0, 0);
    add_vec(A_RIGHT, 8, "12112221.", 0, 0, 0);
    add_vec(A_RIGHT, 9, "12112221.", 0, 0, 0);
    add_vec(A_SEL,   9, "121122211", 0, 3, 1);
    add_vec(A_NEW,   5, ".........", 0, 0, 0);

    // Reset with sel held: nothing may be placed until it is released.
    btn_sel = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    checkOutput("reset", 0, 5, 0, 0, 0);
    wait_cycles(20);
    checkOutput("sel_held_through_reset", 0, 5, 0, 0, 0);
    btn_sel = 1'b0;
    wait_cycles(SETTLE);

    // First press: mark lands after sync + debounce + 1, turn one cycle later.
    btn_sel = 1'b1;
    k = 0;
    while (pos5 == 2'b00 && k < 40) begin
      wait_cycles(1);
      k++;
    end
    check_val("press_latency", k, D + 3);
    check_val("pos5_first", int'(pos5), 1);
    check_val("turn_before_check", int'(turn), 0);
    wait_cycles(1);
    check_val("turn_after_check", int'(turn), 1);
    check_val("over_after_first", int'(game_over), 0);
    btn_sel = 1'b0;
    wait_cycles(SETTLE);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].act, HOLD);
      checkOutput($sformatf("vec%0d", i), tbl[i].board, tbl[i].cur,
                  tbl[i].turn, tbl[i].win, tbl[i].over);
    end

    applyStimulus(A_RIGHT, 2);
    checkOutput("glitch_2", 0, 5, 0, 0, 0);
    applyStimulus(A_RIGHT, D - 1);
    checkOutput("glitch_short", 0, 5, 0, 0, 0);
    applyStimulus(A_RIGHT, D);
    checkOutput("hold_exact", 0, 6, 0, 0, 0);
    applyStimulus(A_RIGHT, 50);
    checkOutput("hold_long", 0, 4, 0, 0, 0);

    btn_sel = 1'b1; btn_up = 1'b1;
    wait_cycles(HOLD);
    btn_sel = 1'b0; btn_up = 1'b0;
    wait_cycles(SETTLE);
    checkOutput("sel_beats_up", bstr("...1....."), 4, 1, 0, 0);

    btn_new = 1'b1; btn_sel = 1'b1;
    wait_cycles(HOLD);
    btn_new = 1'b0; btn_sel = 1'b0;
    wait_cycles(SETTLE);
    checkOutput("new_beats_sel", 0, 5, 0, 0, 0);

    // Asynchronous reset in the middle of a debounce, button kept held after.
    applyStimulus(A_SEL, HOLD);
    checkOutput("pre_reset_mark", bstr("....1...."), 5, 1, 0, 0);
    btn_right = 1'b1;
    wait_cycles(2);
    #3 reset = 1'b1;
    #1 checkOutput("async_reset", 0, 5, 0, 0, 0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(20);
    checkOutput("right_held_through_reset", 0, 5, 0, 0, 0);
    btn_right = 1'b0;
    wait_cycles(SETTLE);

    model_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 6) act = A_SEL;
      else if (r == 19) act = A_NEW;
      else act = A_UP + (r % 4);
      applyStimulus(act, $urandom_range(D, D + 10));
      model_apply(act);
      checkOutput($sformatf("rand%0d", i), model_board(), m_cur, m_turn, m_win, m_over);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Game-state controller for the 3-in-a-row board. Sits directly upstream of the VGA display stage and drives its nine 2-bit cell inputs (pos1..pos9).
- Takes raw push-button inputs, then synchronizes and debounces them.
- Moves a selection cursor, places alternating player marks and detects win or draw.
- Exposes cursor, turn and result signals for display or LED use.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk_25 cycles needed to accept a button level change (10 ms at 25 MHz); bench uses 4.
- CNT_W, 18, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_25  in  1  25 MHz pixel-domain clock
- reset  in  1  asynchronous, active-high
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw, asynchronous, active-high cursor buttons
- btn_sel  in  1  raw, active-high: place mark at cursor
- btn_new  in  1  raw, active-high: start new game
- pos1..pos9  out  2 each  cell state, row-major (1 = top-left); 00 empty, 01 player 1 (red), 10 player 2 (green), 11 never driven
- cursor  out  4  selected cell index, 1..9
- turn  out  1  0 = player 1 to move, 1 = player 2
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw
- game_over  out  1  high in WIN or DRAW state

Behaviour:
- Reset is asynchronous, active-high, on clk_25. Reset values:
  - pos1..pos9 = 00, cursor = 5, turn = 0, winner = 00, game_over = 0
  - state = PLAY, move count = 0
  - debounced levels = 0, debounce counters = 0, synchronizer flops = 0
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synchronized level differs from the debounced level and clears when they match. On reaching DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Press pulse: one-cycle pulse on a debounced 0->1 transition.
  - A held button yields exactly one pulse. Glitches shorter than DEBOUNCE_CYCLES yield none.
- Pulse priority within a single cycle: new > sel > up > down > left > right. Only the highest-priority pulse acts; the others are discarded.
- Cursor movement:
  - Row = (cursor-1)/3, column = (cursor-1)%3.
  - Left/right wrap within the row (3 -> right -> 1, 4 -> left -> 6).
  - Up/down wrap within the column (2 -> up -> 8, 8 -> down -> 2).
  - Cursor updates 1 cycle after the pulse.
  - Moves are honoured in PLAY only; ignored in CHECK, WIN and DRAW.
- State PLAY:
  - Sel pulse on an empty cell: the cell is written with 01 (turn = 0) or 10 (turn = 1), move count increments, next state is CHECK.
  - Sel pulse on an occupied cell: ignored; board, turn and state unchanged.
- State CHECK (exactly 1 cycle), evaluated against the updated board:
  - Lines checked: rows 1-2-3, 4-5-6, 7-8-9; columns 1-4-7, 2-5-8, 3-6-9; diagonals 1-5-9, 3-5-7.
  - Any line all equal to the mover's code: go to WIN, winner = mover's code.
  - Else if move count == 9: go to DRAW, winner = 11.
  - Else: toggle turn and return to PLAY.
  - A win on the 9th move is reported as a win, not a draw.
- Latency: sel pulse registered at cycle N → posK updates at N+1 → winner/game_over/turn update at N+2.
- States WIN and DRAW:
  - Board, turn and winner are frozen; game_over = 1.
  - Only a new pulse is accepted.
- New pulse (any state, including CHECK):
  - Next cycle: all cells = 00, cursor = 5, turn = 0, winner = 00, game_over = 0, move count = 0, state = PLAY.
- Reset asserted mid-debounce or mid-CHECK returns everything to reset values immediately. No pulse is generated on reset release even if a button is held; the button must first be seen released, debounced, then pressed again.
- All outputs are registered. No combinational path from any btn_* input to any output.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Assert reset for 3 cycles, then release → all pos = 00, cursor = 5, turn = 0, winner = 00, game_over = 0. Hold btn_sel through reset release → no mark placed.
2. Press sel at cursor 5 → pos5 = 01 one cycle after the pulse; turn = 1 two cycles after. Press sel again at 5 → pos5 stays 01, turn stays 1.
3. Cursor wrap: from 5, right, right → 6 then 4. Move to 2, then up → 8. Move to 8, then down → 2. Move to 3, then right → 1.
4. Player 1 win, sequence P1 at 1, P2 at 4, P1 at 2, P2 at 5, P1 at 3 → winner = 01, game_over = 1. Subsequent sel/move pulses → no change. btn_new pulse → board cleared, cursor = 5, game_over = 0.
5. Draw, cells in order 1,2,3,5,4,6,8,7,9 → final board P1 {1,3,4,8,9}, P2 {2,5,6,7}; winner = 11 and game_over = 1 after the 9th move.
6. Debounce and priority checks:
   - 2-cycle btn_right glitch → cursor unchanged.
   - btn_right held for 50 cycles → cursor moves exactly one cell.
   - btn_sel and btn_up debounced-pressed in the same cycle → mark placed, cursor unchanged.
